// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main control unit for the 5-stage MIPS datapath.
// Decodes the ID-stage opcode and carries the control word through the
// ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (sticky illegal-opcode flag).
module ctrl_pipe #(
  parameter int INSTR_W    = 32,
  parameter int OPC_MSB    = 31,
  parameter int REG_ADDR_W = 5,
  parameter int HAZ_DETECT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               hazard_stall_o,
  output logic               ex_valid_o,
  output logic [1:0]         ex_alu_op_o,
  output logic               ex_alu_src_o,
  output logic               ex_reg_dst_o,
  output logic               ex_branch_o,
  output logic               ex_jump_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               wb_reg_write_o,
  output logic               wb_mem_to_reg_o,
  output logic               illegal_o
);

  // Control word layout: {reg_write, mem_to_reg, mem_read, mem_write,
  //                       alu_src, reg_dst, branch, jump, alu_op[1:0]}
  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs_id;
  logic [REG_ADDR_W-1:0] rt_id;
  logic [9:0]            dec_ctrl;
  logic                  dec_legal;
  logic                  use_rs;
  logic                  use_rt;
  logic                  dec_valid;
  logic                  hazard_raw;
  logic                  unused_instr_bits;

  logic [9:0]            ex_ctrl_q;
  logic                  ex_valid_q;
  logic [REG_ADDR_W-1:0] ex_rt_q;
  logic [3:0]            mem_ctrl_q;  // reg_write, mem_to_reg, mem_read, mem_write
  logic [1:0]            wb_ctrl_q;   // reg_write, mem_to_reg

  assign opcode = instr_i[OPC_MSB -: 6];
  assign rs_id  = instr_i[21 +: REG_ADDR_W];
  assign rt_id  = instr_i[16 +: REG_ADDR_W];
  assign unused_instr_bits = ^instr_i;

  // Opcode decode, plus which source registers each instruction reads.
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    case (opcode)
      6'b000000: begin dec_ctrl = 10'b1000010010; dec_legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'b001101: begin dec_ctrl = 10'b1000100011; dec_legal = 1'b1; use_rs = 1'b1; end
      6'b001000: begin dec_ctrl = 10'b1000100000; dec_legal = 1'b1; use_rs = 1'b1; end
      6'b100011: begin dec_ctrl = 10'b1110100000; dec_legal = 1'b1; use_rs = 1'b1; end
      6'b101011: begin dec_ctrl = 10'b0001100000; dec_legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'b000100: begin dec_ctrl = 10'b0000001001; dec_legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'b000010: begin dec_ctrl = 10'b0000000100; dec_legal = 1'b1; end
      default:   begin dec_ctrl = '0; dec_legal = 1'b0; end
    endcase
    if (!valid_i) begin
      dec_ctrl = '0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
    end
  end

  assign dec_valid = valid_i & dec_legal;

  // A load in EX whose destination is read by the ID instruction.
  assign hazard_raw = ex_valid_q & ex_ctrl_q[7] & (ex_rt_q != '0) & valid_i &
                      ((use_rs & (ex_rt_q == rs_id)) | (use_rt & (ex_rt_q == rt_id)));

  assign hazard_stall_o = (HAZ_DETECT != 0) & hazard_raw & ~flush_i;

  // Stage registers: stall holds everything; flush or hazard inject a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rt_q    <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
    end else if (!stall_i) begin
      if (flush_i || hazard_stall_o || !dec_valid) begin
        ex_ctrl_q  <= '0;
        ex_valid_q <= 1'b0;
        ex_rt_q    <= '0;
      end else begin
        ex_ctrl_q  <= dec_ctrl;
        ex_valid_q <= 1'b1;
        ex_rt_q    <= rt_id;
      end
      mem_ctrl_q <= ex_ctrl_q[9:6];
      wb_ctrl_q  <= mem_ctrl_q[3:2];
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag for an accepted undefined opcode; cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      illegal_q <= 1'b0;
    else if (valid_i && !dec_legal && !stall_i && !flush_i)
      illegal_q <= 1'b1;
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign ex_valid_o      = ex_valid_q;
  assign ex_alu_op_o     = ex_ctrl_q[1:0];
  assign ex_alu_src_o    = ex_ctrl_q[5];
  assign ex_reg_dst_o    = ex_ctrl_q[4];
  assign ex_branch_o     = ex_ctrl_q[3];
  assign ex_jump_o       = ex_ctrl_q[2];
  assign mem_read_o      = mem_ctrl_q[1];
  assign mem_write_o     = mem_ctrl_q[0];
  assign wb_reg_write_o  = wb_ctrl_q[1];
  assign wb_mem_to_reg_o = wb_ctrl_q[0];

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined main control unit for the 5-stage MIPS datapath.
- Decodes the opcode of the instruction held in IF/ID and carries the control word through the ID/EX, EX/MEM and MEM/WB stage registers.
- Supports external stall and branch/jump flush.
- Detects load-use hazards internally and inserts a bubble while requesting a PC/IF-ID freeze.

Parameters:
- INSTR_W, 32: instruction width.
- OPC_MSB, 31: MSB of the 6-bit opcode field; opcode is instr_i[OPC_MSB -: 6].
- REG_ADDR_W, 5: register-address width; rs = instr_i[25:21], rt = instr_i[20:16].
- HAZ_DETECT, 1: 1 enables load-use detection; 0 ties hazard_stall_o to 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_i  in  INSTR_W  instruction in the ID stage.
- valid_i  in  1  instr_i is a real instruction.
- stall_i  in  1  global freeze (e.g. memory wait).
- flush_i  in  1  kill the ID-stage instruction (taken branch/jump).
- hazard_stall_o  out  1  load-use detected; freeze PC and IF/ID; combinational.
- ex_valid_o  out  1  EX-stage entry valid.
- ex_alu_op_o  out  2  ALU op class.
- ex_alu_src_o  out  1  ALU B operand is the immediate.
- ex_reg_dst_o  out  1  destination is rd (else rt).
- ex_branch_o  out  1  beq in EX.
- ex_jump_o  out  1  j in EX.
- mem_read_o  out  1  load in MEM.
- mem_write_o  out  1  store in MEM.
- wb_reg_write_o  out  1  register write in WB.
- wb_mem_to_reg_o  out  1  WB data source is memory.
- illegal_o  out  1  sticky illegal-opcode flag (optional feature only).

Behaviour:
- Decode table, as {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, branch, jump, alu_op}:
  - 000000 R-type = 1,0,0,0,0,1,0,0,10
  - 001101 ori = 1,0,0,0,1,0,0,0,11
  - 001000 addi = 1,0,0,0,1,0,0,0,00
  - 100011 lw = 1,1,1,0,1,0,0,0,00
  - 101011 sw = 0,0,0,1,1,0,0,0,00
  - 000100 beq = 0,0,0,0,0,0,1,0,01
  - 000010 j = 0,0,0,0,0,0,0,1,00
  - Any other opcode, or valid_i=0, decodes to a bubble (all zero, valid 0).
- Latency: an instruction accepted at edge N drives ex_* after N, mem_* after N+1, wb_* after N+2.
- Stage registers:
  - ID/EX holds the full control word plus rt.
  - EX/MEM holds reg_write, mem_to_reg, mem_read, mem_write.
  - MEM/WB holds reg_write, mem_to_reg.
  - Bubbles propagate as zeros.
- Reset: asynchronous; every output and stage register goes to 0, including illegal_o. Reset mid-stream discards all in-flight entries.
- Per-edge priority (highest first):
  1. rst_i
  2. stall_i: all three stage registers hold; hazard and flush are ignored.
  3. flush_i: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  4. Load-use hazard: ID/EX loads a bubble; later stages advance.
  5. Normal advance.
- Flush handshake: flush_i must be held by the source until a cycle with stall_i=0; a flush during stall_i is not remembered.
- Hazard condition:
  - ID/EX entry is valid with mem_read=1 and rt_ex≠0.
  - The ID instruction is valid and:
    - rt_ex==rs_id for R, ori, addi, lw, sw or beq; or
    - rt_ex==rt_id for R, sw or beq.
  - hazard_stall_o is high the same cycle, masked by flush_i and by HAZ_DETECT=0.
  - hazard_stall_o is not masked by stall_i.
  - The hazard deasserts on the next edge once the load leaves EX; the stall lasts exactly one cycle.
- j and beq do not write registers. Their resolution and flush generation happen outside this block.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode with valid_i=1 (and not stalled or flushed) sets illegal_o on the next edge. illegal_o stays set until rst_i; the instruction still becomes a bubble.
- Undefined: illegal_o is tied to 0 and undefined opcodes silently become bubbles.

Test Plan:
- Reset: rst_i=1 mid-stream with lw in EX, then rst_i=0 -> all outputs 0 immediately; next valid addi (0x20080005) gives ex_alu_src_o=1, ex_alu_op_o=00 after 1 edge.
- Latency: lw 0x8C090000 with valid_i=1 -> ex_alu_src_o=1 at +1, mem_read_o=1 at +2, wb_reg_write_o=1 and wb_mem_to_reg_o=1 at +3, with zeros afterwards.
- Load-use hazard: lw $9 then add $10,$9,$11 (0x012B5020) -> hazard_stall_o=1 for exactly one cycle and ex_valid_o=0 one edge later. Repeat with rt_ex=0 -> no stall.
- Stall/flush: stall_i=1 for 3 cycles with sw in EX -> mem_write_o remains 0 until release. flush_i=1 with beq in ID -> ex_branch_o=0 and ex_valid_o=0 next edge.
- Simultaneous: stall_i=1 and flush_i=1 in the same cycle -> registers hold; flush_i held into the next cycle takes effect then.
- Optional macro on: opcode 111111 with valid_i=1 -> illegal_o=1 after 1 edge, sticky through 10 cycles, cleared only by rst_i. Macro off -> illegal_o stays 0.
